// File: rtl/nnet_frame_arbiter_if.sv
// Stream bundle between nnet_frame_arbiter, its two requesters and the shared core.
// master is the arbiter's view; slave is the surrounding requesters/core.
interface nnet_frame_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] i0_tdata;
    logic             i0_tlast;
    logic             i0_tvalid;
    logic             i0_tready;

    logic [WIDTH-1:0] i1_tdata;
    logic             i1_tlast;
    logic             i1_tvalid;
    logic             i1_tready;

    logic [WIDTH-1:0] o0_tdata;
    logic             o0_tlast;
    logic             o0_tvalid;
    logic             o0_tready;

    logic [WIDTH-1:0] o1_tdata;
    logic             o1_tlast;
    logic             o1_tvalid;
    logic             o1_tready;

    logic [WIDTH-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;

    logic [WIDTH-1:0] s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;

    modport master (
        input  i0_tdata, i0_tlast, i0_tvalid,
        output i0_tready,
        input  i1_tdata, i1_tlast, i1_tvalid,
        output i1_tready,
        output o0_tdata, o0_tlast, o0_tvalid,
        input  o0_tready,
        output o1_tdata, o1_tlast, o1_tvalid,
        input  o1_tready,
        output m_axis_tdata, m_axis_tvalid,
        input  m_axis_tready,
        input  s_axis_tdata, s_axis_tvalid,
        output s_axis_tready
    );

    modport slave (
        output i0_tdata, i0_tlast, i0_tvalid,
        input  i0_tready,
        output i1_tdata, i1_tlast, i1_tvalid,
        input  i1_tready,
        input  o0_tdata, o0_tlast, o0_tvalid,
        output o0_tready,
        input  o1_tdata, o1_tlast, o1_tvalid,
        output o1_tready,
        input  m_axis_tdata, m_axis_tvalid,
        output m_axis_tready,
        output s_axis_tdata, s_axis_tvalid,
        input  s_axis_tready
    );
endinterface

// File: rtl/nnet_frame_arbiter.sv
// Round-robin frame arbiter sharing one neural-net core between two requesters.
// Forces exact input/output frame sizes (pad short, drop long) and generates result tlast.
module nnet_frame_arbiter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SIZE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [SIZE_W-1:0]     nnet_size_in,
    input  logic [SIZE_W-1:0]     nnet_size_out,
    nnet_frame_arbiter_if.master  bus,
    output logic                  grant,
    output logic                  busy,
    output logic                  err_short,
    output logic                  err_long
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SIZE_W-1:0] size_in_q, size_in_d;
    logic [SIZE_W-1:0] size_out_q, size_out_d;
    logic [SIZE_W-1:0] in_cnt_q, in_cnt_d;
    logic [SIZE_W-1:0] out_cnt_q, out_cnt_d;
    logic              grant_d;
    logic              prio_q, prio_d;
    logic              pad_q, pad_d;
    logic              eof_q, eof_d;
    logic              err_short_d, err_long_d;

    // Granted-requester views of the input stream and result ready
    logic [WIDTH-1:0]  sel_tdata;
    logic              sel_tlast;
    logic              sel_tvalid;
    logic              sel_o_tready;

    // Internal stream controls, steered to the granted requester below
    logic [WIDTH-1:0]  feed_tdata;
    logic              feed_tvalid;
    logic              in_tready;
    logic [WIDTH-1:0]  res_tdata;
    logic              res_tvalid;
    logic              res_tlast;
    logic              res_tready;

    always_comb begin
        sel_tdata    = grant ? bus.i1_tdata  : bus.i0_tdata;
        sel_tlast    = grant ? bus.i1_tlast  : bus.i0_tlast;
        sel_tvalid   = grant ? bus.i1_tvalid : bus.i0_tvalid;
        sel_o_tready = grant ? bus.o1_tready : bus.o0_tready;
    end

    // Next-state and stream control
    always_comb begin
        state_d     = state_q;
        size_in_d   = size_in_q;
        size_out_d  = size_out_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        grant_d     = grant;
        prio_d      = prio_q;
        pad_d       = pad_q;
        eof_d       = eof_q;
        err_short_d = err_short;
        err_long_d  = err_long;
        feed_tdata  = '0;
        feed_tvalid = 1'b0;
        in_tready   = 1'b0;
        res_tdata   = '0;
        res_tvalid  = 1'b0;
        res_tlast   = 1'b0;
        res_tready  = 1'b0;

        case (state_q)
            IDLE: begin
                if ((nnet_size_in != '0) && (nnet_size_out != '0) &&
                    (bus.i0_tvalid || bus.i1_tvalid)) begin
                    // prio 0: take 0 unless only 1 is valid; prio 1: the mirror
                    grant_d    = prio_q ? bus.i1_tvalid : !bus.i0_tvalid;
                    size_in_d  = nnet_size_in;
                    size_out_d = nnet_size_out;
                    in_cnt_d   = '0;
                    out_cnt_d  = '0;
                    pad_d      = 1'b0;
                    eof_d      = 1'b0;
                    state_d    = RUN;
                end
            end

            RUN: begin
                if (in_cnt_q < size_in_q) begin
                    if (pad_q) begin
                        feed_tvalid = 1'b1;
                        if (bus.m_axis_tready) begin
                            in_cnt_d = in_cnt_q + SIZE_W'(1);
                        end
                    end else begin
                        feed_tdata  = sel_tdata;
                        feed_tvalid = sel_tvalid;
                        in_tready   = bus.m_axis_tready;
                        if (sel_tvalid && bus.m_axis_tready) begin
                            in_cnt_d = in_cnt_q + SIZE_W'(1);
                            if (sel_tlast) begin
                                eof_d = 1'b1;
                                if ((in_cnt_q + SIZE_W'(1)) < size_in_q) begin
                                    pad_d       = 1'b1;
                                    err_short_d = 1'b1;
                                end
                            end
                        end
                    end
                end else if (!eof_q) begin
                    // Frame ran long: swallow words up to and including tlast
                    in_tready = 1'b1;
                    if (sel_tvalid) begin
                        err_long_d = 1'b1;
                        if (sel_tlast) begin
                            eof_d = 1'b1;
                        end
                    end
                end

                if (out_cnt_q < size_out_q) begin
                    res_tready = sel_o_tready;
                    res_tvalid = bus.s_axis_tvalid;
                    res_tdata  = bus.s_axis_tdata;
                    res_tlast  = (out_cnt_q == (size_out_q - SIZE_W'(1)));
                    if (bus.s_axis_tvalid && sel_o_tready) begin
                        out_cnt_d = out_cnt_q + SIZE_W'(1);
                    end
                end

                if ((in_cnt_d == size_in_q) && eof_d && (out_cnt_d == size_out_q)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                prio_d  = !grant;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            size_in_q  <= '0;
            size_out_q <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            grant      <= 1'b0;
            prio_q     <= 1'b0;
            pad_q      <= 1'b0;
            eof_q      <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
        end else if (clear) begin
            // Abort the frame in flight; error history survives
            state_q    <= IDLE;
            size_in_q  <= '0;
            size_out_q <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            grant      <= 1'b0;
            prio_q     <= 1'b0;
            pad_q      <= 1'b0;
            eof_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_in_q  <= size_in_d;
            size_out_q <= size_out_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            grant      <= grant_d;
            prio_q     <= prio_d;
            pad_q      <= pad_d;
            eof_q      <= eof_d;
            err_short  <= err_short_d;
            err_long   <= err_long_d;
        end
    end

    assign busy = (state_q != IDLE);

    assign bus.m_axis_tdata  = feed_tdata;
    assign bus.m_axis_tvalid = feed_tvalid;
    assign bus.s_axis_tready = res_tready;

    assign bus.i0_tready = in_tready && !grant;
    assign bus.i1_tready = in_tready &&  grant;

    assign bus.o0_tdata  = grant ? '0 : res_tdata;
    assign bus.o0_tvalid = res_tvalid && !grant;
    assign bus.o0_tlast  = res_tlast  && !grant;
    assign bus.o1_tdata  = grant ? res_tdata : '0;
    assign bus.o1_tvalid = res_tvalid &&  grant;
    assign bus.o1_tlast  = res_tlast  &&  grant;

endmodule

// File: tb/tb_nnet_frame_arbiter.sv
// Directed bench for nnet_frame_arbiter: inputs change on the falling edge,
// outputs are checked 1ns later, state commits on the rising edge.
module tb_nnet_frame_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [15:0] sz_in;
    logic [15:0] sz_out;
    logic        grant;
    logic        busy;
    logic        err_short;
    logic        err_long;

    int n_assert = 0;
    int n_fail   = 0;

    nnet_frame_arbiter_if #(.WIDTH(32)) bus ();

    nnet_frame_arbiter #(.WIDTH(32), .SIZE_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .nnet_size_in  (sz_in),
        .nnet_size_out (sz_out),
        .bus           (bus),
        .grant         (grant),
        .busy          (busy),
        .err_short     (err_short),
        .err_long      (err_long)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fall();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; sz_in = 16'd4; sz_out = 16'd2;
        bus.i0_tdata = '0; bus.i0_tlast = 1'b0; bus.i0_tvalid = 1'b0;
        bus.i1_tdata = '0; bus.i1_tlast = 1'b0; bus.i1_tvalid = 1'b0;
        bus.o0_tready = 1'b0; bus.o1_tready = 1'b0;
        bus.m_axis_tready = 1'b0;
        bus.s_axis_tdata = '0; bus.s_axis_tvalid = 1'b0;

        // Reset values
        fall(); #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_m_tvalid", bus.m_axis_tvalid, 0);
        chk("rst_s_tready", bus.s_axis_tready, 0);
        chk("rst_i0_tready", bus.i0_tready, 0);

        // Basic frame: sizes 4/2 from requester 0
        fall(); reset = 1'b0;
        bus.i0_tvalid = 1'b1; bus.i0_tdata = 32'h1;
        bus.m_axis_tready = 1'b1; bus.o0_tready = 1'b1; bus.o1_tready = 1'b1;
        #1;
        chk("t1_grantcyc_i0_tready", bus.i0_tready, 0);
        chk("t1_grantcyc_m_tvalid", bus.m_axis_tvalid, 0);
        fall(); bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = 32'hA; #1;
        chk("t1_busy", busy, 1);
        chk("t1_w1_m_tdata", bus.m_axis_tdata, 32'h1);
        chk("t1_w1_i0_tready", bus.i0_tready, 1);
        chk("t1_r1_o0_tdata", bus.o0_tdata, 32'hA);
        chk("t1_r1_o0_tlast", bus.o0_tlast, 0);
        chk("t1_r1_o1_tvalid", bus.o1_tvalid, 0);
        fall(); bus.i0_tdata = 32'h2; bus.s_axis_tdata = 32'hB; #1;
        chk("t1_w2_m_tdata", bus.m_axis_tdata, 32'h2);
        chk("t1_r2_o0_tdata", bus.o0_tdata, 32'hB);
        chk("t1_r2_o0_tlast", bus.o0_tlast, 1);
        fall(); bus.i0_tdata = 32'h3; bus.s_axis_tvalid = 1'b0; #1;
        chk("t1_w3_m_tdata", bus.m_axis_tdata, 32'h3);
        chk("t1_drained_s_tready", bus.s_axis_tready, 0);
        fall(); bus.i0_tdata = 32'h4; bus.i0_tlast = 1'b1; #1;
        chk("t1_w4_m_tdata", bus.m_axis_tdata, 32'h4);
        fall(); bus.i0_tvalid = 1'b0; bus.i0_tlast = 1'b0; #1;
        chk("t1_done_busy", busy, 1);
        chk("t1_done_m_tvalid", bus.m_axis_tvalid, 0);
        fall(); #1;
        chk("t1_idle_busy", busy, 0);
        chk("t1_err_short", err_short, 0);
        chk("t1_err_long", err_long, 0);

        // Round robin: both requesters valid at reset release, sizes 1/1
        fall(); reset = 1'b1;
        sz_in = 16'd1; sz_out = 16'd1;
        bus.i0_tvalid = 1'b1; bus.i0_tdata = 32'h10; bus.i0_tlast = 1'b1;
        bus.i1_tvalid = 1'b1; bus.i1_tdata = 32'h20; bus.i1_tlast = 1'b1;
        bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = 32'h99;
        for (int k = 0; k < 4; k++) begin
            fall(); reset = 1'b0; #1;
            chk("rr_idle_busy", busy, 0);
            fall(); #1;
            chk("rr_grant", grant, 32'(k % 2));
            chk("rr_m_tdata", bus.m_axis_tdata, (k % 2 == 1) ? 32'h20 : 32'h10);
            chk("rr_i0_tready", bus.i0_tready, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_i1_tready", bus.i1_tready, (k % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr_o0_tvalid", bus.o0_tvalid, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_o1_tvalid", bus.o1_tvalid, (k % 2 == 1) ? 32'd1 : 32'd0);
            fall(); #1;
            chk("rr_done_busy", busy, 1);
            chk("rr_done_i1_tready", bus.i1_tready, 0);
        end

        // Short frame: sizes 4/1, requester 1 sends 2 words
        fall(); sz_in = 16'd4; sz_out = 16'd1;
        bus.i0_tvalid = 1'b0; bus.i0_tlast = 1'b0;
        bus.i1_tvalid = 1'b1; bus.i1_tdata = 32'h31; bus.i1_tlast = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        fall(); #1;
        chk("sh_grant", grant, 1);
        chk("sh_w1_m_tdata", bus.m_axis_tdata, 32'h31);
        fall(); bus.i1_tdata = 32'h32; bus.i1_tlast = 1'b1; #1;
        chk("sh_w2_m_tdata", bus.m_axis_tdata, 32'h32);
        fall(); bus.i1_tdata = 32'h33; bus.i1_tlast = 1'b0;
        bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = 32'h77; #1;
        chk("sh_pad1_m_tdata", bus.m_axis_tdata, 32'h0);
        chk("sh_pad1_m_tvalid", bus.m_axis_tvalid, 1);
        chk("sh_pad1_i1_tready", bus.i1_tready, 0);
        chk("sh_err_short", err_short, 1);
        chk("sh_o1_tdata", bus.o1_tdata, 32'h77);
        chk("sh_o1_tlast", bus.o1_tlast, 1);
        fall(); bus.s_axis_tvalid = 1'b0; #1;
        chk("sh_pad2_m_tvalid", bus.m_axis_tvalid, 1);
        chk("sh_pad2_m_tdata", bus.m_axis_tdata, 32'h0);
        fall(); bus.i1_tvalid = 1'b0; #1;
        chk("sh_done_busy", busy, 1);
        chk("sh_done_m_tvalid", bus.m_axis_tvalid, 0);

        // Long frame: sizes 2/1, requester 0 sends 5 words
        fall(); sz_in = 16'd2; sz_out = 16'd1;
        bus.i0_tvalid = 1'b1; bus.i0_tdata = 32'h41; bus.i0_tlast = 1'b0;
        fall(); bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = 32'h55; #1;
        chk("lg_grant", grant, 0);
        chk("lg_w1_m_tdata", bus.m_axis_tdata, 32'h41);
        chk("lg_o0_tlast", bus.o0_tlast, 1);
        fall(); bus.i0_tdata = 32'h42; bus.s_axis_tvalid = 1'b0; #1;
        chk("lg_w2_m_tdata", bus.m_axis_tdata, 32'h42);
        chk("lg_err_long_pre", err_long, 0);
        fall(); bus.i0_tdata = 32'h43; #1;
        chk("lg_w3_m_tvalid", bus.m_axis_tvalid, 0);
        chk("lg_w3_i0_tready", bus.i0_tready, 1);
        fall(); bus.i0_tdata = 32'h44; #1;
        chk("lg_err_long", err_long, 1);
        chk("lg_w4_m_tvalid", bus.m_axis_tvalid, 0);
        fall(); bus.i0_tdata = 32'h45; bus.i0_tlast = 1'b1; #1;
        chk("lg_w5_i0_tready", bus.i0_tready, 1);
        chk("lg_w5_busy", busy, 1);
        fall(); bus.i0_tvalid = 1'b0; bus.i0_tlast = 1'b0; #1;
        chk("lg_done_busy", busy, 1);
        fall(); #1;
        chk("lg_idle_busy", busy, 0);

        // Result backpressure: sizes 1/3, o0_tready toggles
        fall(); sz_in = 16'd1; sz_out = 16'd3;
        bus.i0_tvalid = 1'b1; bus.i0_tdata = 32'h51; bus.i0_tlast = 1'b1;
        bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = 32'hC0; bus.o0_tready = 1'b1;
        fall(); #1;
        chk("bp_m_tdata", bus.m_axis_tdata, 32'h51);
        chk("bp_r1_s_tready", bus.s_axis_tready, 1);
        chk("bp_r1_o0_tdata", bus.o0_tdata, 32'hC0);
        chk("bp_r1_o0_tlast", bus.o0_tlast, 0);
        fall(); bus.i0_tvalid = 1'b0; bus.i0_tlast = 1'b0;
        bus.o0_tready = 1'b0; bus.s_axis_tdata = 32'hC1; #1;
        chk("bp_stall1_s_tready", bus.s_axis_tready, 0);
        chk("bp_stall1_o0_tvalid", bus.o0_tvalid, 1);
        chk("bp_stall1_o0_tlast", bus.o0_tlast, 0);
        fall(); bus.o0_tready = 1'b1; #1;
        chk("bp_r2_s_tready", bus.s_axis_tready, 1);
        chk("bp_r2_o0_tdata", bus.o0_tdata, 32'hC1);
        chk("bp_r2_o0_tlast", bus.o0_tlast, 0);
        fall(); bus.o0_tready = 1'b0; bus.s_axis_tdata = 32'hC2; #1;
        chk("bp_stall2_s_tready", bus.s_axis_tready, 0);
        chk("bp_stall2_o0_tlast", bus.o0_tlast, 1);
        fall(); bus.o0_tready = 1'b1; #1;
        chk("bp_r3_s_tready", bus.s_axis_tready, 1);
        chk("bp_r3_o0_tdata", bus.o0_tdata, 32'hC2);
        chk("bp_r3_o0_tlast", bus.o0_tlast, 1);
        fall(); #1;
        chk("bp_done_o0_tvalid", bus.o0_tvalid, 0);
        chk("bp_done_s_tready", bus.s_axis_tready, 0);

        // Synchronous clear at in_cnt=2 of 4
        fall(); sz_in = 16'd4; sz_out = 16'd1; bus.s_axis_tvalid = 1'b0;
        bus.i0_tvalid = 1'b1; bus.i0_tdata = 32'h61; bus.i0_tlast = 1'b0;
        fall(); #1;
        chk("cl_w1_m_tdata", bus.m_axis_tdata, 32'h61);
        fall(); bus.i0_tdata = 32'h62; #1;
        chk("cl_w2_m_tdata", bus.m_axis_tdata, 32'h62);
        fall(); bus.i0_tdata = 32'h63; clear = 1'b1; #1;
        chk("cl_pre_busy", busy, 1);
        fall(); clear = 1'b0; bus.i0_tvalid = 1'b0; sz_in = 16'd1; sz_out = 16'd1; #1;
        chk("cl_busy", busy, 0);
        chk("cl_m_tvalid", bus.m_axis_tvalid, 0);
        chk("cl_o0_tvalid", bus.o0_tvalid, 0);
        chk("cl_err_short_kept", err_short, 1);
        chk("cl_err_long_kept", err_long, 1);
        fall(); bus.i0_tvalid = 1'b1; bus.i0_tdata = 32'h71; bus.i0_tlast = 1'b1;
        bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = 32'h81;
        fall(); #1;
        chk("cl_next_m_tdata", bus.m_axis_tdata, 32'h71);
        chk("cl_next_o0_tdata", bus.o0_tdata, 32'h81);
        chk("cl_next_o0_tlast", bus.o0_tlast, 1);
        fall(); bus.i0_tvalid = 1'b0; bus.i0_tlast = 1'b0; bus.s_axis_tvalid = 1'b0; #1;
        chk("cl_next_done_busy", busy, 1);

        // Async reset in the middle of a requester 1 frame
        fall(); sz_in = 16'd4; sz_out = 16'd4;
        bus.i1_tvalid = 1'b1; bus.i1_tdata = 32'h91; bus.i1_tlast = 1'b0;
        fall(); #1;
        chk("ar_pre_grant", grant, 1);
        chk("ar_pre_i1_tready", bus.i1_tready, 1);
        #1 reset = 1'b1;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_grant", grant, 0);
        chk("ar_i1_tready", bus.i1_tready, 0);
        chk("ar_m_tvalid", bus.m_axis_tvalid, 0);
        chk("ar_m_tdata", bus.m_axis_tdata, 32'h0);
        chk("ar_err_short", err_short, 0);
        chk("ar_err_long", err_long, 0);

        // Zero input size: no grant
        fall(); reset = 1'b0; bus.i1_tvalid = 1'b0;
        sz_in = 16'd0; sz_out = 16'd3; bus.i0_tvalid = 1'b1; bus.i0_tdata = 32'hE0;
        for (int c = 0; c < 3; c++) begin
            fall(); #1;
            chk("zs_busy", busy, 0);
            chk("zs_i0_tready", bus.i0_tready, 0);
            chk("zs_i1_tready", bus.i1_tready, 0);
            chk("zs_m_tvalid", bus.m_axis_tvalid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
